// File: rtl/snowflake_pkg.sv
// Shared types and constants for the snowflake sprite: controller FSM states,
// LFSR feedback and the colour codes understood by the sprite source.
package snowflake_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } fall_state_t;

  localparam logic [15:0] LfsrMask = 16'hB400;

  localparam logic [1:0] ColorBlue      = 2'd0;
  localparam logic [1:0] ColorLightBlue = 2'd1;
  localparam logic [1:0] ColorDarkBlue  = 2'd2;
  localparam logic [1:0] ColorMuddyBlue = 2'd3;

  // Right-shifting Galois step: the bit shifted out folds back through the mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LfsrMask) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous reload of the seed and a single-step enable.
module lfsr16
  import snowflake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/snowflake_fall_ctrl.sv
// Per-frame snowflake animation: fall, pseudo-random drift, respawn at a random
// column and periodic colour cycling, all stepped on accepted frame ticks.
module snowflake_fall_ctrl
  import snowflake_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned SPR   = 32,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        restart,
  input  logic        frame_tick,
  input  logic [3:0]  speed,
  input  logic        drift_en,
  input  logic [7:0]  color_period,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [1:0]  ctrl,
  output logic        wrap_pulse
);

  localparam logic [10:0] XMax  = 11'(H_RES - SPR);
  localparam logic [11:0] YLim  = 12'(V_RES - SPR);
  localparam logic [10:0] XInit = 11'((H_RES - SPR) / 2);

  fall_state_t state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        accept;

  logic [15:0] lfsr_q;
  logic [11:0] ny;
  logic        respawn;
  logic [10:0] lfsr_low;
  logic [10:0] respawn_x;
  logic [10:0] drift_x;
  logic [7:0]  cnt_inc;
  logic        unused_lfsr;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (restart),
    .step   (accept),
    .q      (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[14:10];

  assign ny        = {1'b0, y_q} + {8'd0, speed};
  assign respawn   = (ny >= YLim);
  // Fold the 10-bit sample into [0, XMax); valid because 2*XMax >= 1024.
  assign lfsr_low  = {1'b0, lfsr_q[9:0]};
  assign respawn_x = (lfsr_low < XMax) ? lfsr_low : (lfsr_low - XMax);
  assign drift_x   = lfsr_q[15] ? ((x_q >= XMax) ? XMax : (x_q + 11'd1))
                                : ((x_q == 11'd0) ? 11'd0 : (x_q - 11'd1));
  assign cnt_inc   = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    accept  = 1'b0;

    if (restart) begin
      state_d = IDLE;
      x_d     = XInit;
      y_d     = 11'd0;
      ctrl_d  = ColorBlue;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) state_d = RUN;
        end
        RUN: begin
          if (!en) begin
            state_d = PAUSE;
          end else if (frame_tick) begin
            accept = 1'b1;
            if (respawn) begin
              y_d    = 11'd0;
              x_d    = respawn_x;
              wrap_d = 1'b1;
            end else begin
              y_d = ny[10:0];
              if (drift_en) x_d = drift_x;
            end
            if (color_period != 8'd0) begin
              if (cnt_inc == color_period) begin
                cnt_d  = 8'd0;
                ctrl_d = ctrl_q + 2'd1;
              end else begin
                cnt_d = cnt_inc;
              end
            end
          end
        end
        PAUSE: begin
          if (en) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= XInit;
      y_q     <= 11'd0;
      ctrl_q  <= ColorBlue;
      cnt_q   <= 8'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign x0         = x_q;
  assign y0         = y_q;
  assign ctrl       = ctrl_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_snowflake_fall_ctrl.sv
// Directed bench for snowflake_fall_ctrl: fall, respawn, drift saturation,
// colour cycling, pause/resume, restart and asynchronous reset.
module tb_snowflake_fall_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic        drift_en = 1'b0;
  logic [7:0]  color_period = 8'd0;
  logic [10:0] x0;
  logic [10:0] y0;
  logic [1:0]  ctrl;
  logic        wrap_pulse;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] m_l;
  int          m_x;
  int          m_y;
  int          exp_r;

  always #5 clk = ~clk;

  snowflake_fall_ctrl #(
    .H_RES(640),
    .V_RES(480),
    .SPR  (32),
    .SEED (SEED)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .restart     (restart),
    .frame_tick  (frame_tick),
    .speed       (speed),
    .drift_en    (drift_en),
    .color_period(color_period),
    .x0          (x0),
    .y0          (y0),
    .ctrl        (ctrl),
    .wrap_pulse  (wrap_pulse)
  );

  function automatic logic [15:0] model_lfsr(input logic [15:0] v);
    logic [15:0] s;
    s = {1'b0, v[15:1]};
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  function automatic int model_r(input logic [15:0] v);
    int low;
    low = int'(v[9:0]);
    return (low < 608) ? low : low - 608;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_l = SEED;
    m_x = 304;
    m_y = 0;
  endtask

  // One accepted frame tick; the model follows the frame-update rules.
  task automatic tick();
    int ny;
    @(negedge clk);
    frame_tick = 1'b1;
    ny = m_y + int'(speed);
    if (ny >= 448) begin
      m_y = 0;
      m_x = model_r(m_l);
    end else begin
      m_y = ny;
      if (drift_en) begin
        if (m_l[15]) m_x = (m_x >= 608) ? 608 : m_x + 1;
        else m_x = (m_x == 0) ? 0 : m_x - 1;
      end
    end
    m_l = model_lfsr(m_l);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_x0", 32'(x0), 32'd304);
    chk("reset_y0", 32'(y0), 32'd0);
    chk("reset_ctrl", 32'(ctrl), 32'd0);
    chk("reset_wrap", 32'(wrap_pulse), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;

    // Steady fall at speed 4.
    speed = 4'd4;
    tick();
    chk("fall_y0_1", 32'(y0), 32'd4);
    tick();
    chk("fall_y0_2", 32'(y0), 32'd8);
    tick();
    chk("fall_y0_3", 32'(y0), 32'd12);
    chk("fall_x0", 32'(x0), 32'd304);
    chk("fall_ctrl", 32'(ctrl), 32'd0);

    // Climb to 435, then one tick at speed 15 crosses 448 and respawns.
    speed = 4'd3;
    tick();
    chk("fall_y0_15", 32'(y0), 32'd15);
    speed = 4'd15;
    repeat (28) tick();
    chk("pre_wrap_y0", 32'(y0), 32'd435);
    chk("pre_wrap_x0", 32'(x0), 32'd304);
    exp_r = model_r(m_l);
    tick();
    chk("wrap_y0", 32'(y0), 32'd0);
    chk("wrap_x0", 32'(x0), 32'(exp_r));
    chk("wrap_pulse_hi", 32'(wrap_pulse), 32'd1);
    @(negedge clk);
    chk("wrap_pulse_lo", 32'(wrap_pulse), 32'd0);

    // Walk right to 608 by enabling drift only when it moves right.
    speed = 4'd0;
    for (int i = 0; i < 4000 && m_x != 608; i++) begin
      drift_en = m_l[15];
      tick();
    end
    chk("reach_right", 32'(x0), 32'd608);
    for (int i = 0; i < 64 && !m_l[15]; i++) begin
      drift_en = 1'b0;
      tick();
    end
    drift_en = 1'b1;
    tick();
    chk("sat_right", 32'(x0), 32'd608);

    // Walk left to 0 the same way.
    for (int i = 0; i < 5000 && m_x != 0; i++) begin
      drift_en = ~m_l[15];
      tick();
    end
    chk("reach_left", 32'(x0), 32'd0);
    for (int i = 0; i < 64 && m_l[15]; i++) begin
      drift_en = 1'b0;
      tick();
    end
    drift_en = 1'b1;
    tick();
    chk("sat_left", 32'(x0), 32'd0);

    // Colour steps every third tick.
    drift_en = 1'b0;
    color_period = 8'd3;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("ctrl_t%0d", t), 32'(ctrl), 32'((t / 3) % 4));
    end
    color_period = 8'd0;

    // Restart, then pause/resume behaviour.
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_reset();
    chk("restart_x0", 32'(x0), 32'd304);
    chk("restart_y0", 32'(y0), 32'd0);
    speed = 4'd4;
    repeat (4) tick();
    chk("pre_pause_y0", 32'(y0), 32'd16);
    @(negedge clk);
    en = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("pause_tick_y0", 32'(y0), 32'd16);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("paused_y0", 32'(y0), 32'd16);
    @(negedge clk);
    en = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("resume_tick_y0", 32'(y0), 32'd16);
    tick();
    chk("resumed_y0", 32'(y0), 32'd20);

    // Restart coincident with a tick; the next tick lands in IDLE and is ignored.
    @(negedge clk);
    restart = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    frame_tick = 1'b0;
    model_reset();
    chk("rst_tick_x0", 32'(x0), 32'd304);
    chk("rst_tick_y0", 32'(y0), 32'd0);
    chk("rst_tick_ctrl", 32'(ctrl), 32'd0);
    // LFSR back at SEED: 16'hACE1 then 16'hE270, both with bit 15 set.
    speed = 4'd0;
    drift_en = 1'b1;
    color_period = 8'd1;
    tick();
    chk("seed_x0_1", 32'(x0), 32'd305);
    chk("seed_ctrl_1", 32'(ctrl), 32'd1);
    tick();
    chk("seed_x0_2", 32'(x0), 32'd306);
    drift_en = 1'b0;
    speed = 4'd4;
    tick();
    chk("pre_areset_y0", 32'(y0), 32'd4);
    chk("pre_areset_ctrl", 32'(ctrl), 32'd3);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_x0", 32'(x0), 32'd304);
    chk("areset_y0", 32'(y0), 32'd0);
    chk("areset_ctrl", 32'(ctrl), 32'd0);
    chk("areset_wrap", 32'(wrap_pulse), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snowflake_fall_ctrl.md
# snowflake_fall_ctrl

Per-frame animation controller for the snowflake sprite source. It generates the sprite origin (`x0`, `y0`) and the 2-bit colour-select `ctrl`, and updates them once per video frame. The snowflake falls at a programmable speed, drifts sideways pseudo-randomly, respawns at the top at a random column, and cycles its body colour. It sits between the frame-timing logic (which supplies `frame_tick`) and the sprite source's `x0`/`y0`/`ctrl` inputs.

## Interface
Parameters:
- `H_RES`, 640: active horizontal pixels.
- `V_RES`, 480: active vertical lines.
- `SPR`, 32: sprite edge size in pixels.
- `SEED`, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable. Level-sensitive.
- `restart`  in  1  synchronous return to initial state. Single-cycle pulse.
- `frame_tick`  in  1  one-cycle pulse at start of vertical blank.
- `speed`  in  4  pixels moved down per frame. 0 freezes vertical motion.
- `drift_en`  in  1  enables ±1 horizontal drift per frame.
- `color_period`  in  8  frames between colour steps. 0 holds the colour.
- `x0`  out  11  sprite origin x.
- `y0`  out  11  sprite origin y.
- `ctrl`  out  2  colour select for the sprite source.
- `wrap_pulse`  out  1  one-cycle pulse on respawn.

## Operation
- States:
  - IDLE: outputs at initial values; frames ignored.
  - RUN: frames processed.
  - PAUSE: all outputs and LFSR held.
- Transitions:
  - IDLE→RUN when `en`=1.
  - RUN→PAUSE when `en`=0.
  - PAUSE→RUN when `en`=1.
  - Any state→IDLE when `restart`=1. `restart` has priority over `en` and `frame_tick`.
- Initial values (reset and `restart`): `x0` = (H_RES−SPR)/2 = 304, `y0` = 0, `ctrl` = 0, colour counter = 0, LFSR = SEED, `wrap_pulse` = 0.
- LFSR: 16-bit Galois, mask 16'hB400. Advances exactly once per frame_tick accepted in RUN.
- Frame update, in RUN only, when `frame_tick`=1 (XMAX = H_RES−SPR = 608):
  - Vertical:
    - ny = `y0` + `speed`, computed 12 bits wide.
    - If ny ≥ V_RES − SPR (448): respawn. `y0` ← 0, `x0` ← R, `wrap_pulse` ← 1.
    - R = L[9:0] if L[9:0] < XMAX, else L[9:0] − XMAX. L is the LFSR value before the advance.
    - Parameter constraint: 2·XMAX ≥ 1024.
    - Otherwise `y0` ← ny.
  - Horizontal, non-respawn frames with `drift_en`=1:
    - L[15]=1 → `x0`+1, saturating at XMAX.
    - L[15]=0 → `x0`−1, saturating at 0.
    - Respawn overrides drift.
  - Colour:
    - If `color_period`≠0: counter increments. When counter+1 == `color_period`, counter ← 0 and `ctrl` ← `ctrl`+1 (wraps 3→0).
    - Changing `color_period` below the current count: counter wraps naturally at 8 bits; no special handling.
- `speed`, `drift_en` and `color_period` are sampled only in the `frame_tick` cycle.

## Timing
- All outputs registered. An update is visible one clock after the `frame_tick` cycle.
- `wrap_pulse` is high for exactly that one cycle.
- `en` and `frame_tick` in the same cycle while in IDLE or PAUSE: state changes, tick ignored. The first processed tick is the next one.
- `en`=0 coincident with `frame_tick` in RUN: tick ignored, go to PAUSE.
- Asynchronous reset mid-frame: outputs go to initial values immediately; no pending update survives.
- `frame_tick` asserted on consecutive cycles: each accepted in RUN is processed independently.

## Structure
- A shared package `snowflake_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, PAUSE} fall_state_t`
  - LFSR mask constant
  - colour-code constants (blue, light blue, dark blue, muddy blue = 0..3), shared with the sprite source.
- One sub-module `lfsr16`: ports clk, reset_n, load (seed), step, q[15:0]. All other logic stays in the top module.

## Test plan
- Reset, then `en`=1, `speed`=4, `drift_en`=0, 3 ticks → `y0` = 4, 8, 12; `x0` stays 304; `ctrl`=0.
- `speed`=15, run until y0=435, one tick → `y0`=0, `x0`=R from the model LFSR, `wrap_pulse` high exactly 1 cycle.
- `drift_en`=1, force `x0` to 608 via model sequence, L[15]=1 → `x0` stays 608. Mirror case at 0 with L[15]=0 → stays 0.
- `color_period`=3, 12 ticks → `ctrl` steps at ticks 3, 6, 9, 12: 1, 2, 3, 0.
- `en` low at tick 5 with tick → outputs frozen. `en` high together with the next tick → no update on that tick, update on the following one.
- `restart` coincident with `frame_tick` in RUN → initial values, state IDLE, LFSR = SEED. `reset_n` low mid-run → all outputs initial, asynchronously.
